next_pc_predictor: RTL

- Fetch-stage next-PC unit that directly consumes the branch target buffer's lookup result (target address plus response handshake).
- Holds the architectural fetch PC and drives the BTB lookup.
- Combines the BTB target with a 2-bit saturating-counter pattern history table (PHT) to produce the next fetch PC.
- Applies EX-stage branch resolution: counter training and misprediction redirect.

---
 rtl/next_pc_predictor_pkg.sv | 26 ++
 rtl/next_pc_predictor_pht.sv | 31 +++
 rtl/next_pc_predictor.sv | 104 ++++++++++
 3 files changed

// File: rtl/next_pc_predictor_pkg.sv
// Shared types for the fetch-stage next-PC predictor.
// Counter encodings, FSM states and the saturating update helper.
package predictor_types;

    typedef logic [1:0] counter_t;

    localparam counter_t SNT = 2'b00;
    localparam counter_t WNT = 2'b01;
    localparam counter_t WT  = 2'b10;
    localparam counter_t ST  = 2'b11;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        READY  = 2'd1,
        DRAIN  = 2'd2
    } fetch_state_t;

    function automatic counter_t sat_update(input counter_t c,
                                            input logic taken);
        counter_t r;
        if (taken) r = (c == ST) ? ST : c + 2'b01;
        else       r = (c == SNT) ? SNT : c - 2'b01;
        return r;
    endfunction

endpackage

// File: rtl/next_pc_predictor_pht.sv
// Pattern history table of 2-bit saturating counters.
// Combinational read, synchronous training write; no read bypass.
module pht
    import predictor_types::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output counter_t            rd_ctr,
    input  logic                we,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    counter_t ctr [2**IDX_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_BITS; i++) begin
                ctr[i] <= WNT;
            end
        end else if (we) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
        end
    end

    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC unit: drives BTB lookups, combines the BTB
// target with PHT direction, and applies EX training and redirects.
module next_pc_predictor
    import predictor_types::*;
#(
    parameter int          PHT_IDX_BITS = 6,
    parameter logic [31:0] RESET_PC     = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        btb_read,
    output logic [31:0] btb_pc,
    input  logic [31:0] btb_target,
    input  logic        btb_resp,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc
);

    fetch_state_t state;
    logic [31:0]  lookup_pc;
    counter_t     rd_ctr;
    logic         dir;
    logic [31:0]  drain_pc;

    pht #(.IDX_BITS(PHT_IDX_BITS)) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_pc[PHT_IDX_BITS+1:2]),
        .rd_ctr   (rd_ctr),
        .we       (ex_update),
        .wr_idx   (ex_pc[PHT_IDX_BITS+1:2]),
        .wr_taken (ex_taken)
    );

    assign dir      = rd_ctr[1];
    assign btb_read = (state != READY);
    assign btb_pc   = lookup_pc;
    // A redirect landing on the drain's final cycle must restart there
    assign drain_pc = ex_redirect ? ex_redirect_pc : fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOOKUP;
            fetch_pc    <= RESET_PC;
            lookup_pc   <= RESET_PC;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'd0;
        end else begin
            unique case (state)
                LOOKUP: begin
                    if (ex_redirect) begin
                        fetch_pc   <= ex_redirect_pc;
                        pred_valid <= 1'b0;
                        if (btb_resp) begin
                            lookup_pc <= ex_redirect_pc;
                            state     <= LOOKUP;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (btb_resp) begin
                        pred_taken  <= dir;
                        pred_target <= dir ? btb_target : fetch_pc + 32'd4;
                        pred_valid  <= 1'b1;
                        state       <= READY;
                    end
                end
                READY: begin
                    if (ex_redirect) begin
                        fetch_pc   <= ex_redirect_pc;
                        lookup_pc  <= ex_redirect_pc;
                        pred_valid <= 1'b0;
                        state      <= LOOKUP;
                    end else if (!stall) begin
                        fetch_pc   <= pred_target;
                        lookup_pc  <= pred_target;
                        pred_valid <= 1'b0;
                        state      <= LOOKUP;
                    end
                end
                DRAIN: begin
                    fetch_pc   <= drain_pc;
                    pred_valid <= 1'b0;
                    if (btb_resp) begin
                        lookup_pc <= drain_pc;
                        state     <= LOOKUP;
                    end
                end
                default: begin
                    state <= LOOKUP;
                end
            endcase
        end
    end

endmodule
